// File: rtl/nios2_mult_share_arbiter.sv
`timescale 1ns/1ps
// nios2_mult_share_arbiter
//   Lets two requesters share one pipelined 32x32->32 (low word) multiplier.
//   Round-robin grant, registered operand issue, and a tag pipeline that carries
//   the owner of each issued op alongside the multiplier so the product lands
//   in the right per-requester response register.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   rX_valid/rX_ready/rX_src1/2   operand request handshake, requester X
//   rX_rsp_valid/ready/result     product response handshake, requester X
//   mul_src1/2                    registered operands to the multiplier cell
//   mul_result                    cell product, MUL_LATENCY cycles after operands
//   busy                          an issue is in flight or a response is pending

// Per-requester response slot: outstanding flag plus held product.
//   accept_i     op from this requester issued this cycle
//   cpl_i        this requester's product is on cpl_data_i this cycle
//   rsp_ready_i  consumer takes the product
//   pend_o       an op is outstanding (issued, not yet handed back)
module nios2_mult_share_rsp #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              accept_i,
   input  logic              cpl_i,
   input  logic [DATA_W-1:0] cpl_data_i,
   input  logic              rsp_ready_i,
   output logic              pend_o,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] result_o
);
   logic              pend_q, pend_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] res_q, res_d;

   // accept and handshake never coincide (accept needs ~pend, rsp_valid implies
   // pend); completion and handshake never coincide either, so order is free.
   always_comb begin
      pend_d = pend_q;
      vld_d  = vld_q;
      res_d  = res_q;
      if (accept_i) pend_d = 1'b1;
      if (vld_q && rsp_ready_i) begin
         vld_d  = 1'b0;
         pend_d = 1'b0;
      end
      if (cpl_i) begin
         vld_d = 1'b1;
         res_d = cpl_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= 1'b0;
         vld_q  <= 1'b0;
         res_q  <= '0;
      end else begin
         pend_q <= pend_d;
         vld_q  <= vld_d;
         res_q  <= res_d;
      end
   end

   assign pend_o      = pend_q;
   assign rsp_valid_o = vld_q;
   assign result_o    = res_q;
endmodule

module nios2_mult_share_arbiter #(
   parameter int DATA_W      = 32,
   parameter int MUL_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_src1,
   input  logic [DATA_W-1:0] r0_src2,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   output logic [DATA_W-1:0] r0_result,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_src1,
   input  logic [DATA_W-1:0] r1_src2,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [DATA_W-1:0] r1_result,
   output logic [DATA_W-1:0] mul_src1,
   output logic [DATA_W-1:0] mul_src2,
   input  logic [DATA_W-1:0] mul_result,
   output logic              busy
);
   localparam int NREQ   = 2;
   // one stage for the operand register, then the cell latency
   localparam int TDEPTH = MUL_LATENCY + 1;

   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   logic [NREQ-1:0]             valid_v, rsp_rdy_v, pend, elig, gnt, cpl, rsp_vld;
   logic [NREQ-1:0][DATA_W-1:0] src1_v, src2_v, result_v;

   logic                        last_q, last_d;
   logic [DATA_W-1:0]           src1_q, src1_d, src2_q, src2_d;
   tag_t [TDEPTH-1:0]           tag_q, tag_d;
   tag_t                        tag_in, tag_out;
   logic                        any_acc, acc_id, tag_busy;

   assign valid_v   = {r1_valid, r0_valid};
   assign rsp_rdy_v = {r1_rsp_ready, r0_rsp_ready};
   assign src1_v    = {r1_src1, r0_src1};
   assign src2_v    = {r1_src2, r0_src2};

   // A grant only goes to an eligible requester, so a grant is an accept.
   assign elig = valid_v & ~pend;
   always_comb begin
      gnt = '0;
      unique case (elig)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end
   assign any_acc = |gnt;
   assign acc_id  = gnt[1];

   always_comb begin
      last_d     = last_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      tag_in.vld = any_acc;
      tag_in.id  = acc_id;
      if (any_acc) begin
         last_d = acc_id;
         src1_d = src1_v[acc_id];
         src2_d = src2_v[acc_id];
      end
      tag_d = {tag_q[TDEPTH-2:0], tag_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
         src1_q <= '0;
         src2_q <= '0;
         tag_q  <= '0;
      end else begin
         last_q <= last_d;
         src1_q <= src1_d;
         src2_q <= src2_d;
         tag_q  <= tag_d;
      end
   end

   // Oldest tag lines up with mul_result for the op it describes.
   assign tag_out = tag_q[TDEPTH-1];

   for (genvar g = 0; g < NREQ; g++) begin : g_rsp
      assign cpl[g] = tag_out.vld && (tag_out.id == 1'(g));
      nios2_mult_share_rsp #(.DATA_W(DATA_W)) u_rsp (
         .clk         (clk),
         .reset_n     (reset_n),
         .accept_i    (gnt[g]),
         .cpl_i       (cpl[g]),
         .cpl_data_i  (mul_result),
         .rsp_ready_i (rsp_rdy_v[g]),
         .pend_o      (pend[g]),
         .rsp_valid_o (rsp_vld[g]),
         .result_o    (result_v[g])
      );
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < TDEPTH; i++) tag_busy = tag_busy | tag_q[i].vld;
   end

   assign r0_ready     = gnt[0];
   assign r1_ready     = gnt[1];
   assign r0_rsp_valid = rsp_vld[0];
   assign r1_rsp_valid = rsp_vld[1];
   assign r0_result    = result_v[0];
   assign r1_result    = result_v[1];
   assign mul_src1     = src1_q;
   assign mul_src2     = src2_q;
   assign busy         = tag_busy | (|rsp_vld);
endmodule
